// File: rtl/mulu256.sv
// Sequential unsigned multiplier: radix-2 shift-add, one multiplier bit per clock, full 2N-bit product.
// Latency: N+1 edges from accepted start to data_rdy (1 edge for a zero operand).
// Backpressure: none; start is accepted only in IDLE/DONE, and the result holds until the next accept or reset.
module mulu256 #(
  parameter int N = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] mcand,
  input  logic [N-1:0] mplier,
  output logic [N-1:0] prod_hi,
  output logic [N-1:0] prod_lo,
  output logic         zero,
  output logic [2:0]   state,
  output logic         data_rdy
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CALC = 3'd1,
    DONE = 3'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     m_q, m_d;
  logic [2*N:0]     acc_q, acc_d;      // {carry, hi, lo}
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N-1:0]     prod_hi_q, prod_hi_d;
  logic [N-1:0]     prod_lo_q, prod_lo_d;
  logic             zero_q, zero_d;
  logic             data_rdy_q, data_rdy_d;

  logic [N:0]       add_sum;
  logic [N:0]       step_hi;
  logic [2*N:0]     acc_shift;

  // Next-state and datapath: one conditional add of m into the upper half, then a right shift.
  always_comb begin
    state_d    = state_q;
    m_d        = m_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    prod_hi_d  = prod_hi_q;
    prod_lo_d  = prod_lo_q;
    zero_d     = zero_q;
    data_rdy_d = data_rdy_q;

    add_sum   = {1'b0, acc_q[2*N-1:N]} + {1'b0, m_q};
    step_hi   = acc_q[0] ? add_sum : acc_q[2*N:N];
    // Post-add carry lands in the MSB of hi; the freed top bit is zero.
    acc_shift = {1'b0, step_hi, acc_q[N-1:1]};

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if ((mcand == '0) || (mplier == '0)) begin
            // Zero operand: result is known immediately, skip the iteration.
            prod_hi_d  = '0;
            prod_lo_d  = '0;
            zero_d     = 1'b1;
            data_rdy_d = 1'b1;
            state_d    = DONE;
          end else begin
            m_d        = mcand;
            acc_d      = {1'b0, {N{1'b0}}, mplier};
            cnt_d      = CW'(N);
            zero_d     = 1'b0;
            data_rdy_d = 1'b0;
            prod_hi_d  = '0;
            prod_lo_d  = '0;
            state_d    = CALC;
          end
        end
      end
      CALC: begin
        acc_d = acc_shift;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          // Last multiplier bit: publish the shifted value directly.
          prod_hi_d  = acc_shift[2*N-1:N];
          prod_lo_d  = acc_shift[N-1:0];
          data_rdy_d = 1'b1;
          state_d    = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      m_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      prod_hi_q  <= '0;
      prod_lo_q  <= '0;
      zero_q     <= 1'b0;
      data_rdy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      prod_hi_q  <= prod_hi_d;
      prod_lo_q  <= prod_lo_d;
      zero_q     <= zero_d;
      data_rdy_q <= data_rdy_d;
    end
  end

  assign prod_hi  = prod_hi_q;
  assign prod_lo  = prod_lo_q;
  assign zero     = zero_q;
  assign state    = state_q;
  assign data_rdy = data_rdy_q;

endmodule

// File: tb/tb_mulu256.sv
// Scoreboard bench for mulu256: expected products are queued at launch and checked at completion.
// Latency: checks N+1 edges for normal operands and 1 edge for the zero shortcut.
// Backpressure: exercises start ignored in CALC and start held high across DONE.
module tb_mulu256;

  localparam int N = 256;
  localparam int W = 2 * N;

  typedef struct packed {
    logic [W-1:0] prod;
    logic         zero;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] mcand = '0;
  logic [N-1:0] mplier = '0;
  logic [N-1:0] prod_hi;
  logic [N-1:0] prod_lo;
  logic         zero;
  logic [2:0]   state;
  logic         data_rdy;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  mulu256 #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mcand    (mcand),
    .mplier   (mplier),
    .prod_hi  (prod_hi),
    .prod_lo  (prod_lo),
    .zero     (zero),
    .state    (state),
    .data_rdy (data_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] model_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [W-1:0] x;
    logic [W-1:0] y;
    x = W'(a);
    y = W'(b);
    return x * y;
  endfunction

  // Drive operands and queue the expected result; start is left high for the caller to manage.
  task automatic push_op(input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    mcand  = a;
    mplier = b;
    start  = 1'b1;
    e.prod = model_mul(a, b);
    e.zero = (a == '0) || (b == '0);
    sb.push_back(e);
  endtask

  task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b);
    push_op(a, b);
    tick();
    start = 1'b0;
  endtask

  // Wait (bounded) for data_rdy, then check latency, state and the scoreboard head.
  task automatic wait_done(input string tag, input int already, input int exp_lat, output int calc_seen);
    int   edges;
    exp_t e;
    edges     = already;
    calc_seen = 0;
    while (!data_rdy && edges < N + 20) begin
      if (state == 3'd1) calc_seen++;
      tick();
      edges++;
    end
    chk({tag, "_lat"}, W'(edges), W'(exp_lat));
    chk({tag, "_state"}, W'(state), W'(3'd2));
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, W'(1), W'(0));
    end else begin
      e = sb.pop_front();
      chk({tag, "_prod"}, {prod_hi, prod_lo}, e.prod);
      chk({tag, "_zero"}, W'(zero), W'(e.zero));
    end
  endtask

  initial begin
    int           cs;
    logic [W-1:0] held;
    logic [N-1:0] a;
    logic [N-1:0] b;

    tick();
    tick();
    chk("rst_hi", W'(prod_hi), W'(0));
    chk("rst_lo", W'(prod_lo), W'(0));
    chk("rst_zero", W'(zero), W'(0));
    chk("rst_state", W'(state), W'(0));
    chk("rst_rdy", W'(data_rdy), W'(0));
    rst = 1'b0;
    tick();
    chk("idle_state", W'(state), W'(0));

    // All ones: hi = ...FE, lo = 1
    launch('1, '1);
    wait_done("ones", 1, N + 1, cs);
    a = '1;
    a[0] = 1'b0;
    chk("ones_hi_const", W'(prod_hi), W'(a));
    chk("ones_lo_const", W'(prod_lo), W'(1));

    // Small operands with state sequence
    launch(N'(12), N'(5));
    wait_done("small", 1, N + 1, cs);
    chk("small_calc_cycles", W'(cs), W'(N));
    chk("small_lo_const", W'(prod_lo), W'(60));

    // Results hold in DONE without start
    held = {prod_hi, prod_lo};
    repeat (3) tick();
    chk("done_hold", {prod_hi, prod_lo}, held);
    chk("done_hold_rdy", W'(data_rdy), W'(1));

    // Zero shortcut from DONE and then again from DONE
    launch(N'(100), N'(0));
    wait_done("zero_a", 1, 1, cs);
    launch(N'(0), N'(7));
    wait_done("zero_b", 1, 1, cs);

    // Carry into the upper half
    a = '0;
    a[N-1] = 1'b1;
    launch(a, N'(2));
    wait_done("carry", 1, N + 1, cs);
    chk("carry_hi_const", W'(prod_hi), W'(1));
    launch(N'(45), N'(9));
    wait_done("c45x9", 1, N + 1, cs);

    // Reset in the middle of CALC
    launch(N'(45), N'(9));
    chk("launch_rdy_drop", W'(data_rdy), W'(0));
    repeat (99) tick();
    chk("mid_state", W'(state), W'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    void'(sb.pop_front());
    chk("mrst_out", {prod_hi, prod_lo}, W'(0));
    chk("mrst_flags", W'({zero, data_rdy}), W'(0));
    chk("mrst_state", W'(state), W'(0));
    launch(N'(12), N'(5));
    wait_done("after_rst", 1, N + 1, cs);

    // Start and operand changes during CALC are ignored
    launch(N'(7), N'(3));
    repeat (10) tick();
    mcand  = N'(99);
    mplier = N'(77);
    start  = 1'b1;
    tick();
    start  = 1'b0;
    wait_done("ign", 12, N + 1, cs);

    // Start held high across DONE: next op launches on the first DONE edge
    push_op(N'(11), N'(13));
    tick();
    wait_done("hold1", 1, N + 1, cs);
    push_op(N'(1000), N'(3));
    tick();
    chk("hold_rdy_drop", W'(data_rdy), W'(0));
    chk("hold_state", W'(state), W'(1));
    start = 1'b0;
    wait_done("hold2", 1, N + 1, cs);

    // Random wide operands
    for (int r = 0; r < 3; r++) begin
      for (int w = 0; w < N / 32; w++) begin
        a[w*32 +: 32] = $urandom;
        b[w*32 +: 32] = $urandom;
      end
      launch(a, b);
      wait_done("rand", 1, N + 1, cs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
